// File: rtl/orion_pkg.sv
// Shared types and constants for the Orion-PRO ROM-disk PPI responder.
package orion_pkg;

    typedef enum logic [1:0] {
        PPI_A    = 2'd0,
        PPI_B    = 2'd1,
        PPI_C    = 2'd2,
        PPI_CTRL = 2'd3
    } ppi_port_e;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } romdisk_state_e;

    // CTRL register: bit7 selects mode-set, otherwise bit set/reset on port C.
    localparam int CTRL_MODE_BIT    = 7;
    localparam int CTRL_BSR_IDX_HI  = 3;
    localparam int CTRL_BSR_IDX_LO  = 1;
    localparam int CTRL_BSR_VAL_BIT = 0;

    localparam logic [7:0] IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/orion_romdisk_fetch.sv
// Prefetch engine: launches a memory fetch whenever the disk address changes,
// tracks data validity and flags fetches that exceed MAX_LAT cycles.
module orion_romdisk_fetch
    import orion_pkg::*;
#(
    parameter int MEM_AW  = 24,
    parameter int MAX_LAT = 64
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_addr_change,
    input  logic [MEM_AW-1:0] i_next_addr,
    input  logic              i_mem_ack,
    input  logic [7:0]        i_mem_data,
    output logic              o_mem_req,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic              o_valid,
    output logic [7:0]        o_data,
    output logic              o_err_timeout
);

    localparam int               CNT_W      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((MAX_LAT > 0) ? MAX_LAT - 1 : 0);
    localparam bit               TIMEOUT_EN = (MAX_LAT > 0);

    romdisk_state_e    state_q, state_d;
    logic              req_q, req_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic              dirty_q, dirty_d;
    logic              valid_q, valid_d;
    logic [7:0]        data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              to_q, to_d;
    logic              err_q, err_d;
    logic              stale;
    logic              launch;

    // An address write in the current cycle counts as stale immediately, so a
    // simultaneous ack is discarded and the relaunch uses the new address.
    assign stale = dirty_q | i_addr_change;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        dirty_d = stale;
        valid_d = valid_q & ~i_addr_change;
        data_d  = data_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        err_d   = 1'b0;
        launch  = 1'b0;

        case (state_q)
            IDLE: begin
                launch = stale;
            end
            FETCH: begin
                if (i_mem_ack) begin
                    if (stale) begin
                        launch = 1'b1;
                    end else begin
                        if (!to_q) begin
                            data_d  = i_mem_data;
                            valid_d = 1'b1;
                        end
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end else if (!to_q) begin
                    if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                        err_d   = 1'b1;
                        to_d    = 1'b1;
                        data_d  = IDLE_BYTE;
                        valid_d = ~stale;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d = FETCH;
            req_d   = 1'b1;
            addr_d  = i_next_addr;
            dirty_d = 1'b0;
            cnt_d   = '0;
            to_d    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; all next-state
    // math lives in the always_comb above.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            dirty_q <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= IDLE_BYTE;
            cnt_q   <= '0;
            to_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            dirty_q <= dirty_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            err_q   <= err_d;
        end
    end

    assign o_mem_req     = req_q;
    assign o_mem_addr    = addr_q;
    assign o_valid       = valid_q;
    assign o_data        = data_q;
    assign o_err_timeout = err_q;

endmodule

// File: rtl/orion_romdisk_ppi.sv
// Orion-PRO ROM-disk 8255-style port responder: CPU-visible B/C/CTRL registers,
// read mux and wait generation around the prefetch engine.
module orion_romdisk_ppi
    import orion_pkg::*;
#(
    parameter int                MEM_AW  = 24,
    parameter logic [MEM_AW-1:0] BASE    = '0,
    parameter int                MAX_LAT = 64
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_cs,
    input  logic              i_wr,
    input  logic              i_rd,
    input  logic [1:0]        i_addr,
    input  logic [7:0]        i_data,
    output logic [7:0]        o_data,
    output logic              o_wait,
    output logic              o_mem_req,
    output logic [MEM_AW-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [7:0]        i_mem_data,
    output logic              o_err_timeout
);

    ppi_port_e         port;
    logic              wr_en;
    logic [7:0]        reg_b_q, reg_b_d;
    logic [7:0]        reg_c_q, reg_c_d;
    logic              addr_change;
    logic [MEM_AW-1:0] next_addr;
    logic              fetch_valid;
    logic [7:0]        fetch_data;
    logic [7:0]        rd_data;

    assign port  = ppi_port_e'(i_addr);
    assign wr_en = i_cs & i_wr;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        reg_b_d     = reg_b_q;
        reg_c_d     = reg_c_q;
        addr_change = 1'b0;
        if (wr_en) begin
            case (port)
                PPI_B: begin
                    reg_b_d     = i_data;
                    addr_change = 1'b1;
                end
                PPI_C: begin
                    reg_c_d     = i_data;
                    addr_change = 1'b1;
                end
                PPI_CTRL: begin
                    if (i_data[CTRL_MODE_BIT]) begin
                        reg_b_d = '0;
                        reg_c_d = '0;
                    end else begin
                        reg_c_d[i_data[CTRL_BSR_IDX_HI:CTRL_BSR_IDX_LO]] = i_data[CTRL_BSR_VAL_BIT];
                    end
                    addr_change = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            reg_b_q <= '0;
            reg_c_q <= '0;
        end else begin
            reg_b_q <= reg_b_d;
            reg_c_q <= reg_c_d;
        end
    end

    // Fetch address follows the register values being written this cycle, so a
    // write launches its fetch on the very next cycle.
    assign next_addr = BASE + MEM_AW'({reg_c_d, reg_b_d});

    orion_romdisk_fetch #(
        .MEM_AW  (MEM_AW),
        .MAX_LAT (MAX_LAT)
    ) u_fetch (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_addr_change (addr_change),
        .i_next_addr   (next_addr),
        .i_mem_ack     (i_mem_ack),
        .i_mem_data    (i_mem_data),
        .o_mem_req     (o_mem_req),
        .o_mem_addr    (o_mem_addr),
        .o_valid       (fetch_valid),
        .o_data        (fetch_data),
        .o_err_timeout (o_err_timeout)
    );

    always_comb begin
        rd_data = IDLE_BYTE;
        if (i_cs && i_rd) begin
            case (port)
                PPI_A:   rd_data = fetch_data;
                PPI_B:   rd_data = reg_b_q;
                PPI_C:   rd_data = reg_c_q;
                default: rd_data = IDLE_BYTE;
            endcase
        end
    end

    assign o_data = rd_data;
    assign o_wait = i_cs & i_rd & (port == PPI_A) & ~fetch_valid;

endmodule

// File: tb/tb_orion_romdisk_ppi.sv
// Directed bench for orion_romdisk_ppi with a variable-latency byte-memory model.
module tb_orion_romdisk_ppi;

    localparam int          MEM_AW  = 24;
    localparam logic [23:0] BASE    = 24'h100000;
    localparam int          MAX_LAT = 64;

    localparam logic [1:0] P_A = 2'd0, P_B = 2'd1, P_C = 2'd2, P_CTRL = 2'd3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cs, wr, rd;
    logic [1:0]        addr;
    logic [7:0]        wdata;
    logic [7:0]        o_data;
    logic              o_wait;
    logic              o_mem_req;
    logic [MEM_AW-1:0] o_mem_addr;
    logic              mem_ack = 1'b0;
    logic [7:0]        mem_data = 8'h00;
    logic              o_err_timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    // Memory model state
    int          model_lat  = 3;
    bit          model_mute = 1'b0;
    int          wait_cnt   = 0;
    int          ack_count  = 0;
    logic [23:0] last_ack_addr = '0;

    orion_romdisk_ppi #(
        .MEM_AW  (MEM_AW),
        .BASE    (BASE),
        .MAX_LAT (MAX_LAT)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_cs          (cs),
        .i_wr          (wr),
        .i_rd          (rd),
        .i_addr        (addr),
        .i_data        (wdata),
        .o_data        (o_data),
        .o_wait        (o_wait),
        .o_mem_req     (o_mem_req),
        .o_mem_addr    (o_mem_addr),
        .i_mem_ack     (mem_ack),
        .i_mem_data    (mem_data),
        .o_err_timeout (o_err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Ack is raised for exactly one cycle, model_lat cycles into each request.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (o_mem_req && !model_mute) begin
            wait_cnt++;
            if (wait_cnt >= model_lat) begin
                mem_ack       = 1'b1;
                mem_data      = model_byte(o_mem_addr);
                last_ack_addr = o_mem_addr;
                ack_count++;
                wait_cnt      = 0;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [7:0] d, output int waits);
        cs = 1'b1; rd = 1'b1; addr = a;
        waits = 0;
        #1;
        while (o_wait && waits < 200) begin
            waits++;
            @(negedge clk);
            #1;
        end
        check("read_done", o_wait, 1'b0);
        d = o_data;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int         w;
        int         n;

        reset_n = 1'b0; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 2'd0; wdata = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req",   o_mem_req,     1'b0);
        check("rst_err",   o_err_timeout, 1'b0);
        check("rst_wait",  o_wait,        1'b0);
        check("rst_odata", o_data,        8'hFF);

        // Reset release with a read of A already pending: latency 3 -> 4 wait cycles.
        reset_n = 1'b1;
        cpu_read(P_A, d, w);
        check("t1_waits", w, 4);
        check("t1_data",  d, 8'h5A);
        check("t1_acks",  ack_count, 1);
        check("t1_addr",  last_ack_addr, BASE);

        // Re-read does not advance the address or refetch.
        cpu_read(P_A, d, w);
        check("t1_reread_waits", w, 0);
        check("t1_reread_data",  d, 8'h5A);
        check("t1_reread_acks",  ack_count, 1);
        check("t1_req_idle",     o_mem_req, 1'b0);

        // B then C: the fetch for 0x0034 is overtaken by C, relaunched to 0x1234.
        model_lat = 5;
        cpu_write(P_B, 8'h34);
        cpu_write(P_C, 8'h12);
        cpu_read(P_A, d, w);
        check("t2_waits", w, 9);
        check("t2_data",  d, 8'h7C);
        check("t2_acks",  ack_count, 3);
        check("t2_addr",  last_ack_addr, BASE + 24'h001234);
        cpu_read(P_B, d, w);
        check("t2_rd_b", d, 8'h34);
        check("t2_rd_b_waits", w, 0);
        cpu_read(P_C, d, w);
        check("t2_rd_c", d, 8'h12);

        // B rewritten mid-fetch: first byte (0x1E) discarded.
        model_lat = 10;
        cpu_write(P_B, 8'h56);
        repeat (2) @(negedge clk);
        cpu_write(P_B, 8'h78);
        cpu_read(P_A, d, w);
        check("t3_waits", w, 17);
        check("t3_data",  d, 8'h30);
        check("t3_acks",  ack_count, 5);
        check("t3_addr",  last_ack_addr, BASE + 24'h001278);

        // B write lands in the same cycle as the ack: write wins.
        model_lat = 4;
        cpu_write(P_B, 8'h9A);
        repeat (3) @(negedge clk);
        cpu_write(P_B, 8'hBC);
        cpu_read(P_A, d, w);
        check("t3b_waits", w, 4);
        check("t3b_data",  d, 8'hF4);
        check("t3b_acks",  ack_count, 7);
        check("t3b_addr",  last_ack_addr, BASE + 24'h0012BC);

        // CTRL mode set clears B/C; bit set/reset acts on C.
        model_lat = 2;
        cpu_write(P_B, 8'hFF);
        cpu_write(P_C, 8'hFF);
        cpu_write(P_CTRL, 8'h80);
        cpu_read(P_B, d, w);
        check("t4_b_clr", d, 8'h00);
        cpu_read(P_C, d, w);
        check("t4_c_clr", d, 8'h00);
        cpu_read(P_A, d, w);
        check("t4_a0_data", d, 8'h5A);
        check("t4_a0_addr", last_ack_addr, BASE);
        cpu_write(P_CTRL, 8'h0F);
        cpu_read(P_C, d, w);
        check("t4_bsr_bit7", d, 8'h80);
        cpu_write(P_CTRL, 8'h03);
        cpu_read(P_C, d, w);
        check("t4_bsr_bit1", d, 8'h82);
        cpu_read(P_A, d, w);
        check("t4_a_data", d, 8'hD8);
        check("t4_a_addr", last_ack_addr, BASE + 24'h008200);
        cpu_read(P_CTRL, d, w);
        check("t4_ctrl_rd", d, 8'hFF);
        check("t4_ctrl_waits", w, 0);

        // Memory never acks: timeout pulse exactly MAX_LAT cycles after req rises.
        model_mute = 1'b1;
        cpu_write(P_B, 8'h01);
        #1;
        check("t5_req_up",  o_mem_req,     1'b1);
        check("t5_err_pre", o_err_timeout, 1'b0);
        n = 0;
        while (!o_err_timeout && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t5_to_cycles", n, MAX_LAT);
        @(negedge clk);
        #1;
        check("t5_err_pulse", o_err_timeout, 1'b0);
        check("t5_req_held",  o_mem_req,     1'b1);
        cpu_read(P_A, d, w);
        check("t5_a_waits", w, 0);
        check("t5_a_data",  d, 8'hFF);

        // Reset while the request is still outstanding.
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("t6_req",   o_mem_req,     1'b0);
        check("t6_err",   o_err_timeout, 1'b0);
        check("t6_wait",  o_wait,        1'b0);
        check("t6_odata", o_data,        8'hFF);
        @(negedge clk);
        reset_n    = 1'b1;
        model_mute = 1'b0;
        model_lat  = 3;
        cpu_read(P_B, d, w);
        check("t6_b", d, 8'h00);
        cpu_read(P_C, d, w);
        check("t6_c", d, 8'h00);
        cpu_read(P_A, d, w);
        check("t6_a_data", d, 8'h5A);
        check("t6_a_addr", last_ack_addr, BASE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
